// File: rtl/id_stage_pkg.sv
// Shared decode constants and the ID/EX bundle.
// Imported by the decode stage and its hazard unit.
package id_stage_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic INST_BIOS = 1'b1;

  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_RTYPE  = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
  } id_ex_t;

  function automatic logic [31:0] jal_imm(
    input logic [31:0] inst
  );
    return {{11{inst[31]}}, inst[31], inst[19:12],
            inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/id_stage_hazard_unit.sv
// Load-use detection: operand usage decode plus
// compare against the load currently in EX.
module hazard_unit
  import id_stage_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        id_valid,
  input  logic        ex_load,
  input  logic [4:0]  ex_rd,
  input  logic        mem_flush,
  output logic        load_use
);

  logic [6:0] opc;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       hit;

  assign opc = inst[6:0];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];

  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    unique case (1'b1)
      opc == OPC_LUI,
      opc == OPC_AUIPC,
      opc == OPC_JAL:    uses_rs1 = 1'b0;
      opc == OPC_RTYPE,
      opc == OPC_STORE,
      opc == OPC_BRANCH: uses_rs2 = 1'b1;
      default: ;
    endcase
  end

  assign hit = (uses_rs1 && ex_rd == rs1)
            || (uses_rs2 && ex_rd == rs2);

  assign load_use = id_valid && ex_load
                 && ex_rd != 5'd0 && hit
                 && !mem_flush;

endmodule

// File: rtl/id_stage.sv
// Decode stage: instruction select, wrong-path kill,
// JAL redirect, load-use stall, bypass, ID/EX register.
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_pc,
  input  logic [31:0] bios_dout,
  input  logic [31:0] imem_dout,
  input  logic        ex_stall,
  input  logic        mem_flush,
  input  logic        ex_load,
  input  logic [4:0]  ex_rd,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic        id_stall,
  output logic        id_target_taken,
  output logic [31:0] id_target,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data
);

  logic        id_valid_q;
  logic [31:0] inst;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        advance;
  id_ex_t      id_ex_q;

  function automatic logic [31:0] operand(
    input logic [4:0]  rs,
    input logic [31:0] rf
  );
    if (rs == 5'd0)
      return 32'd0;
    if (wb_we && wb_rd == rs)
      return wb_data;
    return rf;
  endfunction

  // Memory address was last cycle's fetch PC == id_pc
  assign inst = (id_pc[30] == INST_BIOS)
              ? bios_dout : imem_dout;

  assign id_rs1 = inst[19:15];
  assign id_rs2 = inst[24:20];

  assign rs1_data = operand(id_rs1, rf_rd1);
  assign rs2_data = operand(id_rs2, rf_rd2);

  assign id_target = id_pc + jal_imm(inst);
  assign id_target_taken = id_valid_q
                        && inst[6:0] == OPC_JAL
                        && !ex_stall && !mem_flush;

  hazard_unit u_hazard (
    .inst      (inst),
    .id_valid  (id_valid_q),
    .ex_load   (ex_load),
    .ex_rd     (ex_rd),
    .mem_flush (mem_flush),
    .load_use  (id_stall)
  );

  assign advance = (!id_stall && !ex_stall) || mem_flush;

  always_ff @(posedge clk) begin
    if (rst)
      id_valid_q <= 1'b0;
    else if (advance)
      id_valid_q <= !(mem_flush || id_target_taken);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q <= '{valid: 1'b0, pc: 32'd0,
                   inst: NOP_INST, rs1_data: 32'd0,
                   rs2_data: 32'd0};
    end else if (mem_flush) begin
      id_ex_q.valid <= 1'b0;
      id_ex_q.inst  <= NOP_INST;
    end else if (ex_stall) begin
      id_ex_q <= id_ex_q;
    end else if (id_stall || !id_valid_q) begin
      id_ex_q.valid <= 1'b0;
      id_ex_q.inst  <= NOP_INST;
    end else begin
      id_ex_q <= '{valid: 1'b1, pc: id_pc,
                   inst: inst, rs1_data: rs1_data,
                   rs2_data: rs2_data};
    end
  end

  assign ex_valid    = id_ex_q.valid;
  assign ex_pc       = id_ex_q.pc;
  assign ex_inst     = id_ex_q.inst;
  assign ex_rs1_data = id_ex_q.rs1_data;
  assign ex_rs2_data = id_ex_q.rs2_data;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with hand-computed
// expectations for select, kill, JAL, stall, bypass.
module tb_id_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI1  = 32'h0010_0093;
  localparam logic [31:0] JAL20  = 32'h0200_006F;
  localparam logic [31:0] JALM4  = 32'hFFDF_F06F;
  localparam logic [31:0] ADD657 = 32'h0072_8333;
  localparam logic [31:0] ADD607 = 32'h0070_0333;
  localparam logic [31:0] LUI5   = 32'h0002_82B7;
  localparam logic [31:0] ADDI65 = 32'h0072_8313;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_pc;
  logic [31:0] bios_dout;
  logic [31:0] imem_dout;
  logic        ex_stall;
  logic        mem_flush;
  logic        ex_load;
  logic [4:0]  ex_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_stall;
  logic        id_target_taken;
  logic [31:0] id_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_inst;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk             (clk),
    .rst             (rst),
    .id_pc           (id_pc),
    .bios_dout       (bios_dout),
    .imem_dout       (imem_dout),
    .ex_stall        (ex_stall),
    .mem_flush       (mem_flush),
    .ex_load         (ex_load),
    .ex_rd           (ex_rd),
    .wb_we           (wb_we),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .rf_rd1          (rf_rd1),
    .rf_rd2          (rf_rd2),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_stall        (id_stall),
    .id_target_taken (id_target_taken),
    .id_target       (id_target),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_inst         (ex_inst),
    .ex_rs1_data     (ex_rs1_data),
    .ex_rs2_data     (ex_rs2_data)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    id_pc = 32'h4000_0000;
    bios_dout = ADDI1;
    imem_dout = 32'd0;
    ex_stall = 1'b0;
    mem_flush = 1'b0;
    ex_load = 1'b0;
    ex_rd = 5'd0;
    wb_we = 1'b0;
    wb_rd = 5'd0;
    wb_data = 32'd0;
    rf_rd1 = 32'h9999_9999;
    rf_rd2 = 32'd0;
    step();
    step();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_inst", ex_inst, NOP);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_rs1d", ex_rs1_data, 32'd0);

    // first decode after reset is killed
    rst = 1'b0;
    #1;
    chk("rs1_addr", {27'd0, id_rs1}, 32'd0);
    chk("rs2_addr", {27'd0, id_rs2}, 32'd1);
    step();
    chk("first_valid", {31'd0, ex_valid}, 32'd0);
    chk("first_inst", ex_inst, NOP);
    step();
    chk("bios_pc", ex_pc, 32'h4000_0000);
    chk("bios_inst", ex_inst, ADDI1);
    chk("bios_valid", {31'd0, ex_valid}, 32'd1);
    chk("x0_zero", ex_rs1_data, 32'd0);

    // JAL from IMEM, then kill the fall-through
    id_pc = 32'h1000_0100;
    imem_dout = JAL20;
    #1;
    chk("jal_taken", {31'd0, id_target_taken}, 32'd1);
    chk("jal_target", id_target, 32'h1000_0120);
    step();
    chk("jal_ex_inst", ex_inst, JAL20);
    id_pc = 32'h1000_0104;
    imem_dout = ADDI1;
    #1;
    chk("killed_taken", {31'd0, id_target_taken}, 32'd0);
    step();
    chk("killed_valid", {31'd0, ex_valid}, 32'd0);

    // backward JAL wraps below zero
    id_pc = 32'd0;
    imem_dout = JALM4;
    #1;
    chk("jalm4_taken", {31'd0, id_target_taken}, 32'd1);
    chk("jalm4_target", id_target, 32'hFFFF_FFFC);
    step();
    imem_dout = ADDI1;
    step();

    // load-use hazards
    id_pc = 32'h0000_0200;
    imem_dout = ADD657;
    ex_load = 1'b1;
    ex_rd = 5'd5;
    #1;
    chk("lu_rs1", {31'd0, id_stall}, 32'd1);
    step();
    chk("lu_bubble_v", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_i", ex_inst, NOP);
    ex_rd = 5'd7;
    #1;
    chk("lu_rs2", {31'd0, id_stall}, 32'd1);
    ex_rd = 5'd0;
    #1;
    chk("lu_x0", {31'd0, id_stall}, 32'd0);
    imem_dout = LUI5;
    ex_rd = 5'd5;
    #1;
    chk("lu_lui", {31'd0, id_stall}, 32'd0);
    imem_dout = ADDI65;
    ex_rd = 5'd7;
    #1;
    chk("lu_itype_rs2", {31'd0, id_stall}, 32'd0);
    ex_load = 1'b0;

    // writeback bypass
    imem_dout = ADD657;
    wb_we = 1'b1;
    wb_rd = 5'd7;
    wb_data = 32'hDEAD_BEEF;
    rf_rd1 = 32'h1111_1111;
    rf_rd2 = 32'd0;
    step();
    chk("byp_rs2", ex_rs2_data, 32'hDEAD_BEEF);
    chk("byp_rs1", ex_rs1_data, 32'h1111_1111);
    chk("byp_pc", ex_pc, 32'h0000_0200);
    chk("byp_valid", {31'd0, ex_valid}, 32'd1);
    id_pc = 32'h0000_0204;
    imem_dout = ADD607;
    wb_rd = 5'd0;
    rf_rd1 = 32'h5555_5555;
    rf_rd2 = 32'h2222_2222;
    step();
    chk("nobyp_rs2", ex_rs2_data, 32'h2222_2222);
    chk("nobyp_x0", ex_rs1_data, 32'd0);
    wb_we = 1'b0;

    // ex_stall holds ID/EX; flush mid-stall
    id_pc = 32'h0000_0300;
    imem_dout = JAL20;
    ex_stall = 1'b1;
    #1;
    chk("stall_jal", {31'd0, id_target_taken}, 32'd0);
    step();
    chk("hold_pc", ex_pc, 32'h0000_0204);
    chk("hold_inst", ex_inst, ADD607);
    chk("hold_valid", {31'd0, ex_valid}, 32'd1);
    mem_flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_inst", ex_inst, NOP);
    mem_flush = 1'b0;
    step();
    chk("stall3_valid", {31'd0, ex_valid}, 32'd0);
    ex_stall = 1'b0;
    imem_dout = ADDI1;
    step();
    chk("post_flush", {31'd0, ex_valid}, 32'd0);

    // flush beats load-use and JAL
    imem_dout = ADD657;
    ex_load = 1'b1;
    ex_rd = 5'd5;
    mem_flush = 1'b1;
    #1;
    chk("fl_stall", {31'd0, id_stall}, 32'd0);
    step();
    chk("fl_bubble", {31'd0, ex_valid}, 32'd0);
    mem_flush = 1'b0;
    ex_load = 1'b0;
    step();
    chk("fl_next_inv", {31'd0, ex_valid}, 32'd0);
    imem_dout = JAL20;
    mem_flush = 1'b1;
    #1;
    chk("fl_jal", {31'd0, id_target_taken}, 32'd0);
    step();
    mem_flush = 1'b0;
    imem_dout = ADDI1;
    step();
    chk("fl_jal_next", {31'd0, ex_valid}, 32'd0);

    // mid-operation reset
    imem_dout = ADD657;
    ex_load = 1'b1;
    ex_rd = 5'd5;
    #1;
    chk("mr_pre_stall", {31'd0, id_stall}, 32'd1);
    rst = 1'b1;
    step();
    chk("mr_valid", {31'd0, ex_valid}, 32'd0);
    chk("mr_pc", ex_pc, 32'd0);
    chk("mr_rs2d", ex_rs2_data, 32'd0);
    chk("mr_inst", ex_inst, NOP);
    chk("mr_stall", {31'd0, id_stall}, 32'd0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
